// File: rtl/set_scan.sv
// Scans an 8x8 grid one cell per clock, counting the cells whose circle-membership
// flags satisfy the latched region mode, and strobes the count when the sweep ends.
module set_scan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [23:0]      central,
    input  logic [11:0]      radius,
    input  logic [1:0]       mode,
    output logic [5:0]       now,
    output logic [23:0]      cell_central,
    output logic [11:0]      cell_radius,
    input  logic [2:0]       hit,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] candidate
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] mode_q;
    logic       sel;

    // Region selection for the current cell, using the mode captured at start
    always_comb begin
        sel = 1'b0;
        case (mode_q)
            2'd0: sel = hit[2];
            2'd1: sel = hit[2] & hit[1];
            2'd2: sel = hit[2] ^ hit[1];
            2'd3: sel = (hit[2] & hit[1] & ~hit[0]) |
                        (hit[2] & ~hit[1] & hit[0]) |
                        (~hit[2] & hit[1] & hit[0]);
            default: sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode_q       <= 2'd0;
            now          <= 6'd0;
            cell_central <= 24'd0;
            cell_radius  <= 12'd0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            candidate    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        cell_central <= central;
                        cell_radius  <= radius;
                        mode_q       <= mode;
                        now          <= 6'd0;
                        candidate    <= '0;
                        busy         <= 1'b1;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    candidate <= candidate + {{(CNT_W-1){1'b0}}, sel};
                    // The last cell keeps now parked at 63 while the result is presented
                    if (now == 6'd63) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        now <= now + 6'd1;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    now   <= 6'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_scan.sv
// Self-checking bench for set_scan: circle tests on the grid feed hit, and every run's
// count is compared against a direct enumeration of the 64 cells.
module tb_set_scan;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [5:0]       now;
    logic [23:0]      cell_central;
    logic [11:0]      cell_radius;
    logic [2:0]       hit;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] candidate;

    int n_checks = 0;
    int n_fail   = 0;

    set_scan #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .central(central),
        .radius(radius),
        .mode(mode),
        .now(now),
        .cell_central(cell_central),
        .cell_radius(cell_radius),
        .hit(hit),
        .busy(busy),
        .valid(valid),
        .candidate(candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_circle(int x, int y, int cx, int cy, int r);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
    endfunction

    // Three circle tests driven by the cell under scan and the latched circles
    always_comb begin
        hit[2] = in_circle(int'(now[2:0]) + 1, int'(now[5:3]) + 1,
                           int'(cell_central[23:20]), int'(cell_central[19:16]), int'(cell_radius[11:8]));
        hit[1] = in_circle(int'(now[2:0]) + 1, int'(now[5:3]) + 1,
                           int'(cell_central[15:12]), int'(cell_central[11:8]), int'(cell_radius[7:4]));
        hit[0] = in_circle(int'(now[2:0]) + 1, int'(now[5:3]) + 1,
                           int'(cell_central[7:4]), int'(cell_central[3:0]), int'(cell_radius[3:0]));
    end

    function automatic logic [23:0] pack_c(int ax, int ay, int bx, int by, int cx, int cy);
        return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy)};
    endfunction

    function automatic logic [11:0] pack_r(int ra, int rb, int rc);
        return {4'(ra), 4'(rb), 4'(rc)};
    endfunction

    // Reference: enumerate the grid and count cells meeting the region rule
    function automatic int model_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        int total = 0;
        for (int y = 1; y <= 8; y++) begin
            for (int x = 1; x <= 8; x++) begin
                int a = in_circle(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
                int b = in_circle(x, y, int'(c[15:12]), int'(c[11:8]), int'(r[7:4]));
                int k = in_circle(x, y, int'(c[7:4]), int'(c[3:0]), int'(r[3:0]));
                case (m)
                    2'd0: total += a;
                    2'd1: total += (a + b == 2) ? 1 : 0;
                    2'd2: total += (a + b == 1) ? 1 : 0;
                    default: total += (a + b + k == 2) ? 1 : 0;
                endcase
            end
        end
        return total;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launches one run, optionally scrambling inputs while busy, and checks its result and wind-down
    task automatic applyStimulus(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                                 input int exp_cand, input bit disturb, input string tag,
                                 output int last_a_now);
        int edges = 0;
        int cand_seen;
        last_a_now = -1;
        @(negedge clk);
        central = c;
        radius  = r;
        mode    = m;
        en      = 1'b1;
        @(posedge clk);
        while (edges < 200) begin
            @(negedge clk);
            if (valid) break;
            checkOutput({tag, "_busy"}, int'(busy), 1);
            if (hit[2]) last_a_now = int'(now);
            if (edges == 0) begin
                en = 1'b0;
            end else if (disturb) begin
                en      = (now == 6'd10) ? 1'b1 : 1'($urandom_range(0, 1));
                mode    = (now == 6'd10) ? 2'd1 : 2'($urandom_range(0, 3));
                central = 24'($urandom);
                radius  = 12'($urandom);
            end
            @(posedge clk);
            edges++;
        end
        en = 1'b0;
        // Counting the accepting edge as edge 1, valid rises on edge 65
        checkOutput({tag, "_valid_latency"}, edges, 64);
        checkOutput({tag, "_valid"}, int'(valid), 1);
        checkOutput({tag, "_candidate"}, int'(candidate), exp_cand);
        cand_seen = int'(candidate);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, int'(valid), 0);
        checkOutput({tag, "_busy_drop"}, int'(busy), 0);
        checkOutput({tag, "_now_clear"}, int'(now), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_no_extra_run"}, int'(busy), 0);
        checkOutput({tag, "_cand_hold"}, int'(candidate), cand_seen);
    endtask

    typedef struct {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        int          exp_cand;
        int          exp_a_now;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int last_now;
        int edge_n;
        int pulses;
        int last_edge;
        bit prev_valid;
        logic [23:0] rc;
        logic [11:0] rr;
        logic [1:0]  rm;

        vecs[0] = '{pack_c(4, 4, 0, 0, 0, 0), pack_r(0, 0, 0), 2'd0, 1, 27};
        vecs[1] = '{pack_c(4, 4, 0, 0, 0, 0), pack_r(8, 0, 0), 2'd0, 64, -2};
        vecs[2] = '{pack_c(1, 1, 8, 8, 0, 0), pack_r(0, 0, 0), 2'd1, 0, 0};
        vecs[3] = '{pack_c(1, 1, 8, 8, 0, 0), pack_r(0, 0, 0), 2'd2, 2, 0};
        vecs[4] = '{pack_c(4, 4, 4, 4, 8, 8), pack_r(0, 0, 0), 2'd3, 1, -2};

        rst_n   = 1'b0;
        en      = 1'b0;
        central = 24'hFFFFFF;
        radius  = 12'hFFF;
        mode    = 2'd3;
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_now", int'(now), 0);
        checkOutput("reset_candidate", int'(candidate), 0);
        checkOutput("reset_cell_central", int'(cell_central), 0);
        checkOutput("reset_cell_radius", int'(cell_radius), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_hold_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].central, vecs[i].radius, vecs[i].mode, vecs[i].exp_cand,
                          1'b0, $sformatf("vec%0d", i), last_now);
            if (vecs[i].exp_a_now != -2)
                checkOutput($sformatf("vec%0d_last_hit_a", i), last_now,
                            (vecs[i].exp_a_now == 0) ? 0 : vecs[i].exp_a_now);
        end

        // Inputs churn (including an en pulse with mode 1 at now=10) during the run
        applyStimulus(pack_c(4, 4, 0, 0, 0, 0), pack_r(3, 0, 0), 2'd0,
                      model_count(pack_c(4, 4, 0, 0, 0, 0), pack_r(3, 0, 0), 2'd0),
                      1'b1, "disturb", last_now);

        for (int i = 0; i < 10; i++) begin
            rc = pack_c($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                        $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            rr = pack_r($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
            rm = 2'($urandom_range(0, 3));
            applyStimulus(rc, rr, rm, model_count(rc, rr, rm), i[0], $sformatf("rand%0d", i), last_now);
        end

        // Asynchronous reset mid-scan
        @(negedge clk);
        central = pack_c(4, 4, 0, 0, 0, 0);
        radius  = pack_r(8, 0, 0);
        mode    = 2'd0;
        en      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        edge_n = 0;
        while (now != 6'd30 && edge_n < 100) begin
            @(negedge clk);
            edge_n++;
        end
        checkOutput("rst_reach_now30", int'(now), 30);
        checkOutput("rst_partial_cand", int'(candidate), 30);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_valid", int'(valid), 0);
        checkOutput("rst_mid_now", int'(now), 0);
        checkOutput("rst_mid_candidate", int'(candidate), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_after_busy", int'(busy), 0);
        applyStimulus(pack_c(4, 4, 0, 0, 0, 0), pack_r(8, 0, 0), 2'd0, 64, 1'b0, "post_rst", last_now);

        // en held high: back-to-back runs
        @(negedge clk);
        rc = pack_c(5, 3, 2, 6, 7, 7);
        rr = pack_r(4, 3, 5);
        central = rc;
        radius  = rr;
        mode    = 2'd3;
        en      = 1'b1;
        edge_n = 0;
        pulses = 0;
        last_edge = -1;
        prev_valid = 1'b0;
        while (edge_n < 400 && pulses < 3) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            if (prev_valid) checkOutput("b2b_valid_width", int'(valid), 0);
            if (valid && !prev_valid) begin
                pulses++;
                if (last_edge < 0) checkOutput("b2b_first_valid_edge", edge_n, 65);
                else checkOutput("b2b_spacing", edge_n - last_edge, 66);
                last_edge = edge_n;
                checkOutput("b2b_candidate", int'(candidate), model_count(rc, rr, 2'd3));
            end
            prev_valid = valid;
        end
        en = 1'b0;
        checkOutput("b2b_pulse_count", pulses, 3);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_last_width", int'(valid), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
